wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
// Shares one WISHBONE slave port (NIC or memory) among N_MASTER bus masters. Each master is a fake_master-style requester
// driving CYC and waiting on gnt_wb_i. Round-robin arbitration, one grant at a time; the granted master's bus signals go to
// the slave and the slave responses go back to that master only. Sits between the masters and the NIC slave interface.
// PARAMETERS
// N_MASTER        4    number of requesting masters (2..8)
// IDX_W           2    width of the grant index, = clog2(N_MASTER)
// TIMEOUT_CYCLES  256  max cycles one grant may last (used only when WB_ARB_TIMEOUT_EN is defined)
// PORTS
// clk        in   1                     clock, all logic on posedge
// rst        in   1                     reset, synchronous, active-high
// m_cyc_i    in   N_MASTER              CYC_O of each master
// m_stb_i    in   N_MASTER              STB_O of each master
// m_we_i     in   N_MASTER              WE_O of each master
// m_dat_i    in   N_MASTER*BUS_DATA_W   DAT_O of each master, master k at slice k
// m_sel_i    in   N_MASTER*BUS_SEL_W    SEL_O of each master
// m_adr_i    in   N_MASTER*BUS_ADR_W    ADR_O of each master
// m_cti_i    in   N_MASTER*3            CTI_O of each master
// m_gnt_o    out  N_MASTER              gnt_wb_i of each master, one-hot or zero
// m_ack_o/m_rty_o/m_err_o  out  N_MASTER  slave ACK/RTY/ERR routed to the granted master
// m_stall_o  out  N_MASTER              STALL routed to the granted master; 1 for every other master
// m_dat_o    out  BUS_DATA_W            slave DAT_I, broadcast to all masters
// s_cyc_o/s_stb_o/s_we_o/s_dat_o/s_sel_o/s_adr_o/s_cti_o  out  (bus widths)  to slave
// s_dat_i/s_ack_i/s_rty_i/s_err_i/s_stall_i  in  (bus widths)  from slave
// gnt_idx_o  out  IDX_W                 index of the current or last grant
// busy_o     out  1                     high while in GRANT
// BEHAVIOUR
// - Reset: state IDLE, m_gnt_o=0, rr_ptr=0, gnt_idx_o=0, busy_o=0, s_cyc_o=s_stb_o=0, m_ack/rty/err_o=0, m_stall_o=all 1s.
// - IDLE: if any m_cyc_i is set, pick the first requester at or after rr_ptr, with modulo-N wrap.
//   Register gnt_idx_o and m_gnt_o (one-hot), go to GRANT. Latency: CYC seen at edge t -> gnt high after edge t.
// - GRANT: s_* = granted master's signals, with s_cyc_o = m_cyc_i[idx] and s_stb_o = m_stb_i[idx] & m_cyc_i[idx].
//   Slave responses are combinationally routed to the granted master only. Other masters' STB is ignored.
// - GRANT -> IDLE: when m_cyc_i[idx]=0 at a posedge. Clear m_gnt_o and set rr_ptr = idx+1 mod N_MASTER.
//   This gives one dead cycle; the earliest re-grant comes one edge later. Grant is never pre-empted, except by timeout.
// - Simultaneous requests: round-robin order. Request held by a non-granted master: waits, no loss.
// - Master drops CYC mid-burst, including with CTI=010 pending: treated as end of grant, same as a normal release.
// - rst mid-transfer: all state returns to reset values at the next edge; slave CYC drops immediately after that edge.
// CONFIGURATION
// - WB_ARB_TIMEOUT_EN defined: a grant counter increments each GRANT cycle and clears on entry to GRANT.
//   When it reaches TIMEOUT_CYCLES-1:
//   - pulse m_err_o[idx] for 1 cycle and force s_cyc_o=0;
//   - clear m_gnt_o and go to HOLD;
//   - HOLD: stay until m_cyc_i[idx]=0, then go to IDLE with rr_ptr=idx+1. The master is not re-granted while it holds CYC.
// - WB_ARB_TIMEOUT_EN undefined: no counter, no HOLD state; a grant lasts until the master releases CYC.
// STRUCTURE
// - Widths come from NIC-defines.v: BUS_DATA_W=`BUS_DATA_WIDTH, BUS_SEL_W=`BUS_SEL_WIDTH, BUS_ADR_W=`BUS_ADDRESS_WIDTH.
// - Add to NIC-defines.v: state encodings WB_ARB_IDLE=2'd0, WB_ARB_GRANT=2'd1, WB_ARB_HOLD=2'd2.
// - Sub-module rr_picker: combinational. Inputs req[N] and ptr. Outputs valid and idx.
//   Implement as a double-width request vector with a masked priority encoder.
// TESTING
// - Use N_MASTER=4 with fake_master instances and a slave model.
// - Single request: m_cyc_i=0001 at edge 3 -> m_gnt_o=0001 after edge 3, s_cyc_o=1.
//   Slave ACK reaches m_ack_o[0] only; m_stall_o=1110.
// - Concurrent: m_cyc_i=1111 from reset with each master holding 4 cycles -> grant order 0,1,2,3,0.
//   Exactly 1 dead cycle between grants.
// - Pointer wrap: grant 3 released while m_cyc_i=0011 -> next grant 0, then 1.
// - Isolation: a non-granted master drives STB=1 with ADR=0xDEAD -> s_adr_o keeps the granted master's address.
//   That master gets no ACK.
// - Reset mid-burst: rst=1 for 1 cycle during GRANT -> after that edge m_gnt_o=0, s_cyc_o=0, gnt_idx_o=0.
// - Timeout, WB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8: master 1 holds CYC with no ACK.
//   Expect m_err_o[1] 1-cycle pulse after 8 grant cycles and gnt revoked.
//   Master 2 is granted only after master 1 drops CYC.

Source files
------------

// File: rtl/wb_bus_arbiter_pkg.sv
// Shared widths, FSM encodings and helpers for the WISHBONE round-robin arbiter.
// Bus widths follow the NIC-wide defines when present, otherwise fall back to 32/4/32.
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_SEL_WIDTH
`define BUS_SEL_WIDTH 4
`endif
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif

package wb_bus_arbiter_pkg;

    localparam int BUS_DATA_W = `BUS_DATA_WIDTH;
    localparam int BUS_SEL_W  = `BUS_SEL_WIDTH;
    localparam int BUS_ADR_W  = `BUS_ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        WB_ARB_IDLE  = 2'd0,
        WB_ARB_GRANT = 2'd1,
        WB_ARB_HOLD  = 2'd2
    } arb_state_t;

    // Modulo-n increment used to advance the round-robin pointer past the last grant.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Bundle of all master-side and slave-side WISHBONE signals around the arbiter.
// Handshake: a master requests with CYC, transfers when STB=1 and STALL=0, and a cycle ends on ACK/RTY/ERR.
interface wb_bus_arbiter_if
    import wb_bus_arbiter_pkg::*;
#(
    parameter int N_MASTER = 4
);
    logic [N_MASTER-1:0]            m_cyc_i;
    logic [N_MASTER-1:0]            m_stb_i;
    logic [N_MASTER-1:0]            m_we_i;
    logic [N_MASTER*BUS_DATA_W-1:0] m_dat_i;
    logic [N_MASTER*BUS_SEL_W-1:0]  m_sel_i;
    logic [N_MASTER*BUS_ADR_W-1:0]  m_adr_i;
    logic [N_MASTER*3-1:0]          m_cti_i;
    logic [N_MASTER-1:0]            m_gnt_o;
    logic [N_MASTER-1:0]            m_ack_o;
    logic [N_MASTER-1:0]            m_rty_o;
    logic [N_MASTER-1:0]            m_err_o;
    logic [N_MASTER-1:0]            m_stall_o;
    logic [BUS_DATA_W-1:0]          m_dat_o;
    logic                           s_cyc_o;
    logic                           s_stb_o;
    logic                           s_we_o;
    logic [BUS_DATA_W-1:0]          s_dat_o;
    logic [BUS_SEL_W-1:0]           s_sel_o;
    logic [BUS_ADR_W-1:0]           s_adr_o;
    logic [2:0]                     s_cti_o;
    logic [BUS_DATA_W-1:0]          s_dat_i;
    logic                           s_ack_i;
    logic                           s_rty_i;
    logic                           s_err_i;
    logic                           s_stall_i;

    // The arbiter drives the shared slave, so it takes the master view.
    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_dat_i, m_sel_i, m_adr_i, m_cti_i,
        output m_gnt_o, m_ack_o, m_rty_o, m_err_o, m_stall_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_dat_o, s_sel_o, s_adr_o, s_cti_o,
        input  s_dat_i, s_ack_i, s_rty_i, s_err_i, s_stall_i
    );

    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_dat_i, m_sel_i, m_adr_i, m_cti_i,
        input  m_gnt_o, m_ack_o, m_rty_o, m_err_o, m_stall_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_dat_o, s_sel_o, s_adr_o, s_cti_o,
        output s_dat_i, s_ack_i, s_rty_i, s_err_i, s_stall_i
    );
endinterface

// File: rtl/wb_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module wb_bus_arbiter_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);
    logic [2*N-1:0] req2;
    logic [2*N-1:0] masked;
    int             pos;

    // The upper copy is never masked, so wrapped requests are still found in it.
    always_comb begin
        req2 = {req, req};
        for (int i = 0; i < 2*N; i++) begin
            masked[i] = req2[i] && (i >= int'(ptr));
        end
        pos = 0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (masked[i]) pos = i;
        end
        valid = |req;
        idx   = IDX_W'(pos % N);
    end
endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin WISHBONE arbiter sharing one slave port among N_MASTER masters, one grant at a time.
// Optional grant watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int N_MASTER       = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst,
    wb_bus_arbiter_if.master   bus,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               busy_o,
    output arb_state_t         state_o
);
    if (N_MASTER < 2 || N_MASTER > 8 || IDX_W != $clog2(N_MASTER) || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("wb_bus_arbiter: illegal parameter set");
    end

    arb_state_t          state, state_nxt;
    logic [IDX_W-1:0]    gnt_idx, gnt_idx_nxt;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]    pick_idx, rr_after;
    logic [N_MASTER-1:0] gnt, gnt_nxt, gnt_onehot;
    logic                pick_valid, cur_cyc, busy, timeout_hit, resp_en, s_cyc;

    wb_bus_arbiter_rr_picker #(.N(N_MASTER), .IDX_W(IDX_W)) u_picker (
        .req   (bus.m_cyc_i),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign gnt_onehot = N_MASTER'(1) << gnt_idx;
    assign cur_cyc    = bus.m_cyc_i[gnt_idx];
    assign rr_after   = IDX_W'(rr_next(int'(gnt_idx), N_MASTER));
    assign busy       = (state == WB_ARB_GRANT);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] grant_cnt;

    // Counter is zero on the first GRANT cycle because every other state clears it.
    always_ff @(posedge clk) begin
        if (rst || state != WB_ARB_GRANT) grant_cnt <= '0;
        else                              grant_cnt <= grant_cnt + CNT_W'(1);
    end

    assign timeout_hit = busy && (grant_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WB_ARB_IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= gnt_idx_nxt;
            rr_ptr  <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        gnt_idx_nxt = gnt_idx;
        rr_ptr_nxt  = rr_ptr;
        case (state)
            WB_ARB_IDLE: begin
                if (pick_valid) begin
                    state_nxt   = WB_ARB_GRANT;
                    gnt_idx_nxt = pick_idx;
                    gnt_nxt     = N_MASTER'(1) << pick_idx;
                end
            end
            WB_ARB_GRANT: begin
                // A voluntary release wins over a watchdog expiry in the same cycle.
                if (!cur_cyc) begin
                    state_nxt  = WB_ARB_IDLE;
                    gnt_nxt    = '0;
                    rr_ptr_nxt = rr_after;
                end else if (timeout_hit) begin
                    state_nxt = WB_ARB_HOLD;
                    gnt_nxt   = '0;
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            WB_ARB_HOLD: begin
                if (!cur_cyc) begin
                    state_nxt  = WB_ARB_IDLE;
                    rr_ptr_nxt = rr_after;
                end
            end
`endif
            default: state_nxt = WB_ARB_IDLE;
        endcase
    end

    assign resp_en = busy && !timeout_hit;
    assign s_cyc   = resp_en && cur_cyc;

    assign bus.s_cyc_o = s_cyc;
    assign bus.s_stb_o = s_cyc && bus.m_stb_i[gnt_idx];
    assign bus.s_we_o  = bus.m_we_i[gnt_idx];
    assign bus.s_dat_o = bus.m_dat_i[gnt_idx*BUS_DATA_W +: BUS_DATA_W];
    assign bus.s_sel_o = bus.m_sel_i[gnt_idx*BUS_SEL_W +: BUS_SEL_W];
    assign bus.s_adr_o = bus.m_adr_i[gnt_idx*BUS_ADR_W +: BUS_ADR_W];
    assign bus.s_cti_o = bus.m_cti_i[gnt_idx*3 +: 3];

    // Responses reach the granted master only; everyone else sees a permanently stalled bus.
    assign bus.m_ack_o   = {N_MASTER{resp_en && bus.s_ack_i}} & gnt_onehot;
    assign bus.m_rty_o   = {N_MASTER{resp_en && bus.s_rty_i}} & gnt_onehot;
    assign bus.m_err_o   = {N_MASTER{(resp_en && bus.s_err_i) || timeout_hit}} & gnt_onehot;
    assign bus.m_stall_o = busy ? (~gnt_onehot | ({N_MASTER{bus.s_stall_i}} & gnt_onehot))
                                : {N_MASTER{1'b1}};
    assign bus.m_dat_o   = bus.s_dat_i;
    assign bus.m_gnt_o   = gnt;

    assign gnt_idx_o = gnt_idx;
    assign busy_o    = busy;
    assign state_o   = state;
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed self-checking bench for wb_bus_arbiter with four masters driven from tasks.
module tb_wb_bus_arbiter;
  import wb_bus_arbiter_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt_idx;
  logic       busy;
  arb_state_t state;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  wb_bus_arbiter_if #(.N_MASTER(N)) bus ();

  wb_bus_arbiter #(.N_MASTER(N), .IDX_W(2), .TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .gnt_idx_o (gnt_idx),
    .busy_o    (busy),
    .state_o   (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_cyc_i   = '0;
    bus.m_stb_i   = '0;
    bus.m_we_i    = '0;
    bus.m_dat_i   = '0;
    bus.m_sel_i   = '0;
    bus.m_adr_i   = '0;
    bus.m_cti_i   = '0;
    bus.s_dat_i   = 32'hCAFE_0000;
    bus.s_ack_i   = 1'b0;
    bus.s_rty_i   = 1'b0;
    bus.s_err_i   = 1'b0;
    bus.s_stall_i = 1'b0;
  endtask

  task automatic drive_master(input int k, input logic cyc, input logic stb, input logic we, input logic [31:0] adr, input logic [2:0] cti);
    bus.m_cyc_i[k]          = cyc;
    bus.m_stb_i[k]          = stb;
    bus.m_we_i[k]           = we;
    bus.m_adr_i[k*32 +: 32] = adr;
    bus.m_dat_i[k*32 +: 32] = 32'h1111_0000 * (k + 1);
    bus.m_sel_i[k*4 +: 4]   = 4'hF;
    bus.m_cti_i[k*3 +: 3]   = cti;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_checks++; if (state !== WB_ARB_IDLE) $display("FAIL reset_state: got %0d want %0d", state, WB_ARB_IDLE); else n_pass++;
    n_checks++; if (bus.m_gnt_o !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", bus.m_gnt_o); else n_pass++;
    n_checks++; if (gnt_idx !== 2'd0 || busy !== 1'b0) $display("FAIL reset_idx_busy: got idx %0d busy %b want 0 0", gnt_idx, busy); else n_pass++;
    n_checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) $display("FAIL reset_s_cyc: got cyc %b stb %b want 0 0", bus.s_cyc_o, bus.s_stb_o); else n_pass++;
    n_checks++; if (bus.m_stall_o !== 4'b1111) $display("FAIL reset_stall: got %b want 1111", bus.m_stall_o); else n_pass++;
    n_checks++; if ((bus.m_ack_o | bus.m_rty_o | bus.m_err_o) !== 4'b0000) $display("FAIL reset_resp: got %b want 0000", bus.m_ack_o | bus.m_rty_o | bus.m_err_o); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 3'b000);
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", bus.m_gnt_o); else n_pass++;
    n_checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1) $display("FAIL single_s_cyc: got cyc %b stb %b want 1 1", bus.s_cyc_o, bus.s_stb_o); else n_pass++;
    n_checks++; if (bus.s_adr_o !== 32'h0000_0100) $display("FAIL single_adr: got %h want 00000100", bus.s_adr_o); else n_pass++;
    bus.s_ack_i = 1'b1;
    #1;
    n_checks++; if (bus.m_ack_o !== 4'b0001) $display("FAIL single_ack: got %b want 0001", bus.m_ack_o); else n_pass++;
    n_checks++; if (bus.m_stall_o !== 4'b1110) $display("FAIL single_stall: got %b want 1110", bus.m_stall_o); else n_pass++;
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i[0] = 1'b0;
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0000 || busy !== 1'b0) $display("FAIL single_release: got gnt %b busy %b want 0000 0", bus.m_gnt_o, busy); else n_pass++;
  endtask

  task automatic test_concurrent();
    logic [1:0] exp;
    logic [3:0] exp_gnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.m_cyc_i = 4'b1111;
    bus.m_stb_i = 4'b1111;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      exp_gnt = 4'b0001 << exp;
      tick();
      n_checks++; if (bus.m_gnt_o !== exp_gnt || gnt_idx !== exp) $display("FAIL conc_gnt: got %b idx %0d want %b idx %0d", bus.m_gnt_o, gnt_idx, exp_gnt, exp); else n_pass++;
      tick();
      tick();
      tick();
      n_checks++; if (bus.m_gnt_o !== exp_gnt) $display("FAIL conc_hold: got %b want %b", bus.m_gnt_o, exp_gnt); else n_pass++;
      bus.m_cyc_i[exp] = 1'b0;
      tick();
      n_checks++; if (bus.m_gnt_o !== 4'b0000 || busy !== 1'b0) $display("FAIL conc_dead: got gnt %b busy %b want 0000 0", bus.m_gnt_o, busy); else n_pass++;
      bus.m_cyc_i[exp] = 1'b1;
    end
    bus.m_cyc_i = 4'b0000;
    bus.m_stb_i = 4'b0000;
  endtask

  task automatic test_wrap();
    bus.m_cyc_i = 4'b1000;
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b1000) $display("FAIL wrap_gnt3: got %b want 1000", bus.m_gnt_o); else n_pass++;
    bus.m_cyc_i = 4'b1011;
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b1000) $display("FAIL wrap_no_preempt: got %b want 1000", bus.m_gnt_o); else n_pass++;
    bus.m_cyc_i[3] = 1'b0;
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0000) $display("FAIL wrap_dead: got %b want 0000", bus.m_gnt_o); else n_pass++;
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0001) $display("FAIL wrap_gnt0: got %b want 0001", bus.m_gnt_o); else n_pass++;
    bus.m_cyc_i[0] = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0010) $display("FAIL wrap_gnt1: got %b want 0010", bus.m_gnt_o); else n_pass++;
    bus.m_cyc_i = 4'b0000;
    tick();
  endtask

  task automatic test_isolation_and_reset_mid();
    drive_master(2, 1'b1, 1'b1, 1'b1, 32'h0000_2000, 3'b000);
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0100 || gnt_idx !== 2'd2) $display("FAIL iso_gnt: got %b idx %0d want 0100 idx 2", bus.m_gnt_o, gnt_idx); else n_pass++;
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_DEAD, 3'b000);
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'h5A5A_A5A5;
    #1;
    n_checks++; if (bus.s_adr_o !== 32'h0000_2000) $display("FAIL iso_adr: got %h want 00002000", bus.s_adr_o); else n_pass++;
    n_checks++; if (bus.s_we_o !== 1'b1 || bus.s_dat_o !== 32'h3333_0000) $display("FAIL iso_we_dat: got we %b dat %h want 1 33330000", bus.s_we_o, bus.s_dat_o); else n_pass++;
    n_checks++; if (bus.m_ack_o !== 4'b0100) $display("FAIL iso_ack: got %b want 0100", bus.m_ack_o); else n_pass++;
    n_checks++; if (bus.m_stall_o !== 4'b1011) $display("FAIL iso_stall: got %b want 1011", bus.m_stall_o); else n_pass++;
    n_checks++; if (bus.m_dat_o !== 32'h5A5A_A5A5) $display("FAIL iso_rdat: got %h want 5a5aa5a5", bus.m_dat_o); else n_pass++;
    bus.s_ack_i = 1'b0;
    rst = 1'b1;
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0000 || bus.s_cyc_o !== 1'b0) $display("FAIL rstmid_gnt_cyc: got gnt %b cyc %b want 0000 0", bus.m_gnt_o, bus.s_cyc_o); else n_pass++;
    n_checks++; if (gnt_idx !== 2'd0 || busy !== 1'b0) $display("FAIL rstmid_idx: got idx %0d busy %b want 0 0", gnt_idx, busy); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0001) $display("FAIL rstmid_ptr: got %b want 0001", bus.m_gnt_o); else n_pass++;
    bus.m_cyc_i = 4'b0000;
    bus.m_stb_i = 4'b0000;
    tick();
  endtask

  task automatic test_cti_drop();
    drive_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 3'b010);
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0010 || bus.s_cti_o !== 3'b010) $display("FAIL cti_gnt: got %b cti %b want 0010 010", bus.m_gnt_o, bus.s_cti_o); else n_pass++;
    bus.m_cyc_i[1] = 1'b0;
    #1;
    n_checks++; if (bus.s_cyc_o !== 1'b0) $display("FAIL cti_s_cyc: got %b want 0", bus.s_cyc_o); else n_pass++;
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0000 || state !== WB_ARB_IDLE) $display("FAIL cti_release: got %b state %0d want 0000 0", bus.m_gnt_o, state); else n_pass++;
    idle_inputs();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 3'b000);
    drive_master(2, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 3'b000);
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0010 || bus.m_err_o !== 4'b0000) $display("FAIL to_gnt: got %b err %b want 0010 0000", bus.m_gnt_o, bus.m_err_o); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (bus.m_err_o !== 4'b0000 || bus.m_gnt_o !== 4'b0010) $display("FAIL to_early: cycle %0d got err %b gnt %b want 0000 0010", i + 2, bus.m_err_o, bus.m_gnt_o); else n_pass++;
    end
    tick();
    n_checks++; if (bus.m_err_o !== 4'b0010 || bus.s_cyc_o !== 1'b0) $display("FAIL to_err: got err %b cyc %b want 0010 0", bus.m_err_o, bus.s_cyc_o); else n_pass++;
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0000 || bus.m_err_o !== 4'b0000 || state !== WB_ARB_HOLD) $display("FAIL to_hold: got gnt %b err %b state %0d want 0000 0000 2", bus.m_gnt_o, bus.m_err_o, state); else n_pass++;
    tick();
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0000) $display("FAIL to_hold_wait: got %b want 0000", bus.m_gnt_o); else n_pass++;
    bus.m_cyc_i[1] = 1'b0;
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0000 || state !== WB_ARB_IDLE) $display("FAIL to_release: got %b state %0d want 0000 0", bus.m_gnt_o, state); else n_pass++;
    tick();
    n_checks++; if (bus.m_gnt_o !== 4'b0100) $display("FAIL to_next: got %b want 0100", bus.m_gnt_o); else n_pass++;
    idle_inputs();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_concurrent();
    test_wrap();
    test_isolation_and_reset_mid();
    test_cti_drop();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
